// File: rtl/vga_object_scheduler.sv
// Tear-free shadow/active register controller for the Pong renderer; commits land at vblank start.
// Optional vblank interrupt pulse enabled by defining VGA_SCHED_IRQ_EN.
module vga_object_scheduler #(
  parameter int unsigned PADDLE_H  = 64,
  parameter int unsigned BALL_SIZE = 8,
  parameter int unsigned V_ACT_END = 515
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] horizontal_count,
  input  logic [15:0] vertical_count,
  input  logic        wr_req,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  output logic        busy,
  output logic [9:0]  paddle_l_y,
  output logic [9:0]  paddle_r_y,
  output logic [9:0]  ball_x,
  output logic [9:0]  ball_y,
  output logic [11:0] obj_color,
  output logic        display_en,
  output logic        commit_done,
  output logic [15:0] frame_count,
  output logic        vblank_irq
);

  localparam int unsigned POS_W = 10;
  localparam int unsigned COL_W = 12;
  localparam logic [POS_W-1:0] PADDLE_MAX = POS_W'(480 - PADDLE_H);
  localparam logic [POS_W-1:0] BALL_X_MAX = POS_W'(640 - BALL_SIZE);
  localparam logic [POS_W-1:0] BALL_Y_MAX = POS_W'(480 - BALL_SIZE);
  localparam logic [15:0]      VB_LINE    = 16'(V_ACT_END);

  localparam logic [POS_W-1:0] RST_PADDLE = POS_W'(208);
  localparam logic [POS_W-1:0] RST_BALL_X = POS_W'(316);
  localparam logic [POS_W-1:0] RST_BALL_Y = POS_W'(236);
  localparam logic [COL_W-1:0] RST_COLOR  = COL_W'(12'hFFF);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_COMMIT} state_t;

  state_t state, state_next;

  logic [15:0]      v_prev;
  logic [POS_W-1:0] sh_paddle_l, sh_paddle_r, sh_ball_x, sh_ball_y;
  logic [COL_W-1:0] sh_color;
  logic             sh_display_en;

  logic vb_start;
  logic wr_accept;
  logic commit_wr;

  // Debug-only inputs and unused data bits are deliberately folded away
  logic unused_inputs;
  assign unused_inputs = ^{horizontal_count, wr_data[15:12]};

  function automatic logic [POS_W-1:0] clamp(input logic [POS_W-1:0] v, input logic [POS_W-1:0] mx);
    return (v > mx) ? mx : v;
  endfunction

  assign vb_start  = (vertical_count == VB_LINE) && (v_prev != VB_LINE);
  assign wr_accept = wr_req && !wr_ack && (state != ST_COMMIT);
  assign commit_wr = wr_accept && (wr_addr == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // A commit accepted while idle only arms; it cannot consume a vb_start on the same edge
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (commit_wr) state_next = ST_ARMED;
      ST_ARMED:  if (vb_start)  state_next = ST_COMMIT;
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Shadow registers: CPU-visible, clamped on write
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_paddle_l   <= RST_PADDLE;
      sh_paddle_r   <= RST_PADDLE;
      sh_ball_x     <= RST_BALL_X;
      sh_ball_y     <= RST_BALL_Y;
      sh_color      <= RST_COLOR;
      sh_display_en <= 1'b0;
    end else if (wr_accept) begin
      case (wr_addr)
        3'd0: sh_paddle_l   <= clamp(wr_data[POS_W-1:0], PADDLE_MAX);
        3'd1: sh_paddle_r   <= clamp(wr_data[POS_W-1:0], PADDLE_MAX);
        3'd2: sh_ball_x     <= clamp(wr_data[POS_W-1:0], BALL_X_MAX);
        3'd3: sh_ball_y     <= clamp(wr_data[POS_W-1:0], BALL_Y_MAX);
        3'd4: sh_color      <= wr_data[COL_W-1:0];
        3'd5: sh_display_en <= wr_data[0];
        default: ;
      endcase
    end
  end

  // Active registers and handshake/status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      paddle_l_y  <= RST_PADDLE;
      paddle_r_y  <= RST_PADDLE;
      ball_x      <= RST_BALL_X;
      ball_y      <= RST_BALL_Y;
      obj_color   <= RST_COLOR;
      display_en  <= 1'b0;
      commit_done <= 1'b0;
      wr_ack      <= 1'b0;
      busy        <= 1'b0;
      frame_count <= 16'd0;
      v_prev      <= 16'd0;
    end else begin
      commit_done <= (state == ST_COMMIT);
      wr_ack      <= wr_accept;
      busy        <= (state_next != ST_IDLE);
      v_prev      <= vertical_count;
      if (vb_start) frame_count <= frame_count + 16'd1;
      if (state == ST_COMMIT) begin
        paddle_l_y <= sh_paddle_l;
        paddle_r_y <= sh_paddle_r;
        ball_x     <= sh_ball_x;
        ball_y     <= sh_ball_y;
        obj_color  <= sh_color;
        display_en <= sh_display_en;
      end
    end
  end

`ifdef VGA_SCHED_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) vblank_irq <= 1'b0;
    else       vblank_irq <= vb_start;
  end
`else
  assign vblank_irq = 1'b0;
`endif

endmodule

// File: tb/tb_vga_object_scheduler.sv
// Self-checking bench for vga_object_scheduler: vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_vga_object_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] horizontal_count;
  logic [15:0] vertical_count;
  logic        wr_req;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack, busy, display_en, commit_done, vblank_irq;
  logic [9:0]  paddle_l_y, paddle_r_y, ball_x, ball_y;
  logic [11:0] obj_color;
  logic [15:0] frame_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cur_vc = 0;

  always #5 clk = ~clk;

  vga_object_scheduler dut (
    .clk(clk), .reset(reset), .horizontal_count(horizontal_count),
    .vertical_count(vertical_count), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .busy(busy),
    .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y), .ball_x(ball_x),
    .ball_y(ball_y), .obj_color(obj_color), .display_en(display_en),
    .commit_done(commit_done), .frame_count(frame_count), .vblank_irq(vblank_irq)
  );

  // Reference model: shadow/active register files plus a pending-commit flag
  int m_sh[6];
  int m_act[6];
  bit m_pending, m_commit_now, m_ack, m_busy, m_done, m_irq;
  int m_frame, m_vprev;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_reset();
    m_sh  = '{208, 208, 316, 236, 4095, 0};
    m_act = m_sh;
    m_pending = 0; m_commit_now = 0; m_ack = 0; m_busy = 0;
    m_done = 0; m_irq = 0; m_frame = 0; m_vprev = 0;
  endfunction

  function automatic void model_edge(input bit rq, input int a, input int d, input int vc, input bit rs);
    bit vb, acc, was_commit;
    if (rs) begin model_reset(); return; end
    vb  = (vc == 515) && (m_vprev != 515);
    acc = rq && !m_ack && !m_commit_now;
    was_commit = m_commit_now;
    m_done = was_commit;
    if (was_commit) m_act = m_sh;
    if (acc) begin
      case (a)
        0, 1: m_sh[a] = min_i(d % 1024, 416);
        2:    m_sh[2] = min_i(d % 1024, 632);
        3:    m_sh[3] = min_i(d % 1024, 472);
        4:    m_sh[4] = d % 4096;
        5:    m_sh[5] = d % 2;
        default: ;
      endcase
    end
    if (was_commit) m_commit_now = 0;
    else if (m_pending && vb) begin m_pending = 0; m_commit_now = 1; end
    else if (!m_pending && acc && a == 7) m_pending = 1;
    m_ack  = acc;
    m_busy = m_pending || m_commit_now;
    if (vb) m_frame = (m_frame + 1) % 65536;
`ifdef VGA_SCHED_IRQ_EN
    m_irq = vb;
`else
    m_irq = 0;
`endif
    m_vprev = vc;
  endfunction

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void check_all();
    chk("wr_ack", int'(wr_ack), int'(m_ack));
    chk("busy", int'(busy), int'(m_busy));
    chk("paddle_l_y", int'(paddle_l_y), m_act[0]);
    chk("paddle_r_y", int'(paddle_r_y), m_act[1]);
    chk("ball_x", int'(ball_x), m_act[2]);
    chk("ball_y", int'(ball_y), m_act[3]);
    chk("obj_color", int'(obj_color), m_act[4]);
    chk("display_en", int'(display_en), m_act[5]);
    chk("commit_done", int'(commit_done), int'(m_done));
    chk("frame_count", int'(frame_count), m_frame);
    chk("vblank_irq", int'(vblank_irq), int'(m_irq));
  endfunction

  function automatic int get_out(input int a);
    case (a)
      0: return int'(paddle_l_y);
      1: return int'(paddle_r_y);
      2: return int'(ball_x);
      3: return int'(ball_y);
      4: return int'(obj_color);
      default: return int'(display_en);
    endcase
  endfunction

  task automatic tick(input bit rq, input int a, input int d, input int vc, input bit rs);
    reset = rs; wr_req = rq; wr_addr = 3'(a); wr_data = 16'(d);
    vertical_count = 16'(vc); horizontal_count = 16'($urandom_range(0, 799));
    cur_vc = vc;
    @(posedge clk);
    model_edge(rq, a, d, vc, rs);
    #1;
    check_all();
  endtask

  task automatic wr(input int a, input int d);
    tick(1, a, d, cur_vc, 0);
    tick(0, 0, 0, cur_vc, 0);
  endtask

  task automatic frame_pass();
    tick(0, 0, 0, 514, 0);
    tick(0, 0, 0, 515, 0);
    tick(0, 0, 0, 515, 0);
    tick(0, 0, 0, 0, 0);
  endtask

  typedef struct {
    int addr;
    int data;
    int exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int irq_seen;
    vecs = '{
      '{2, 700, 632}, '{3, 500, 472}, '{0, 1000, 416}, '{1, 5, 5},
      '{4, 'hF123, 'h123}, '{5, 'hFFFF, 1}, '{2, 631, 631}, '{3, 'hFC00 + 472, 472},
      '{0, 416, 416}, '{1, 417, 416}, '{5, 2, 0}, '{4, 'h0ABC, 'hABC}
    };

    // Reset and idle frame
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    chk("rst_paddle_l", int'(paddle_l_y), 208);
    chk("rst_paddle_r", int'(paddle_r_y), 208);
    chk("rst_ball_x", int'(ball_x), 316);
    chk("rst_ball_y", int'(ball_y), 236);
    chk("rst_color", int'(obj_color), 'hFFF);
    chk("rst_display_en", int'(display_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame", int'(frame_count), 0);
    tick(0, 0, 0, 0, 0);
    frame_pass();
    chk("idle_frame_count", int'(frame_count), 1);
    chk("idle_ball_x", int'(ball_x), 316);

    // Clamp/decode table: write, commit, cross vblank, read active register
    foreach (vecs[i]) begin
      wr(vecs[i].addr, vecs[i].data);
      wr(7, 0);
      chk("tbl_busy_armed", int'(busy), 1);
      frame_pass();
      chk($sformatf("tbl_addr%0d", vecs[i].addr), get_out(vecs[i].addr), vecs[i].exp);
    end

    // Commit timing: ball_x=700 lands as 632 two cycles after vb_start
    wr(2, 700);
    wr(7, 0);
    tick(0, 0, 0, 514, 0);
    tick(0, 0, 0, 515, 0);
    chk("cmt_not_yet_done", int'(commit_done), 0);
    chk("cmt_busy_n1", int'(busy), 1);
    tick(0, 0, 0, 515, 0);
    chk("cmt_ball_x", int'(ball_x), 632);
    chk("cmt_done_pulse", int'(commit_done), 1);
    chk("cmt_busy_drop", int'(busy), 0);
    tick(0, 0, 0, 515, 0);
    chk("cmt_done_once", int'(commit_done), 0);

    // Uncommitted write stays hidden over two frames
    wr(0, 100);
    frame_pass();
    frame_pass();
    chk("nocommit_paddle", int'(paddle_l_y), 416);

    // Commit on same edge as vb_start from idle misses this frame
    tick(0, 0, 0, 514, 0);
    tick(1, 7, 0, 515, 0);
    chk("same_edge_busy", int'(busy), 1);
    tick(0, 0, 0, 515, 0);
    tick(0, 0, 0, 515, 0);
    chk("same_edge_no_done", int'(commit_done), 0);
    chk("same_edge_paddle_old", int'(paddle_l_y), 416);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 514, 0);
    tick(0, 0, 0, 515, 0);
    tick(0, 0, 0, 515, 0);
    chk("same_edge_next_frame", int'(paddle_l_y), 100);
    chk("same_edge_done", int'(commit_done), 1);

    // Write during COMMIT is stalled one cycle and only reaches shadow
    tick(0, 0, 0, 0, 0);
    wr(2, 100);
    wr(7, 0);
    tick(0, 0, 0, 514, 0);
    tick(0, 0, 0, 515, 0);
    tick(1, 2, 200, 515, 0);
    chk("stall_no_ack", int'(wr_ack), 0);
    chk("stall_ball_x", int'(ball_x), 100);
    tick(1, 2, 200, 515, 0);
    chk("stall_ack_late", int'(wr_ack), 1);
    tick(0, 0, 0, 0, 0);
    chk("stall_shadow_only", int'(ball_x), 100);
    wr(7, 0);
    frame_pass();
    chk("stall_next_commit", int'(ball_x), 200);

    // Reset while armed discards the pending commit
    wr(0, 50);
    wr(7, 0);
    tick(0, 0, 0, 0, 1);
    chk("rstarm_busy", int'(busy), 0);
    chk("rstarm_paddle", int'(paddle_l_y), 208);
    chk("rstarm_ball_x", int'(ball_x), 316);
    chk("rstarm_frame", int'(frame_count), 0);
    irq_seen = 0;
    for (int f = 0; f < 2; f++) begin
      tick(0, 0, 0, 514, 0);
      tick(0, 0, 0, 515, 0);
      irq_seen += int'(vblank_irq);
      tick(0, 0, 0, 515, 0);
      chk("rstarm_no_done", int'(commit_done), 0);
      irq_seen += int'(vblank_irq);
      tick(0, 0, 0, 0, 0);
      irq_seen += int'(vblank_irq);
    end
    chk("rstarm_paddle_after", int'(paddle_l_y), 208);
`ifdef VGA_SCHED_IRQ_EN
    chk("irq_per_frame", irq_seen, 2);
`else
    chk("irq_tied_low", irq_seen, 0);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      int vc;
      vc = (cur_vc >= 525 || cur_vc < 505) ? 505 : cur_vc + (($urandom % 3 == 0) ? 0 : 1);
      tick(bit'($urandom % 2), int'($urandom % 8), int'($urandom % 65536), vc,
           bit'($urandom % 600 == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
